fetch_sched: RTL
================

# fetch_sched

Fetch-stage controller for the pipelined MIPS core. It drives the `Req`, `stall` and `npc` inputs of the IFU PC register each cycle, arbitrating between several sources:

- exception entry,
- `eret`,
- D-stage branch/jump redirects,
- hazard stalls,
- instruction-memory wait states.

It also tracks delay-slot status and F/D flush/valid qualification for the fetched instruction.

## Interface
Parameters:
- `EXC_VEC`, 32'h0000_4180, exception handler entry address.
- `RESET_PC`, 32'h0000_3000, documentation only; the IFU owns the reset value.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `pc_f`  in  32  current IFU PC.
- `imem_ready`  in  1  instruction word for `pc_f` is valid this cycle.
- `hz_stall`  in  1  hazard unit holds F and D.
- `exc_req`  in  1  exception/interrupt taken (CP0, M stage).
- `eret_d`  in  1  `eret` in D.
- `epc`  in  32  CP0 EPC.
- `br_d`  in  1  branch/jump instruction in D, taken or not.
- `br_taken_d`  in  1  D branch/jump resolved taken.
- `br_target_d`  in  32  redirect target.
- `ifu_req`  out  1  to IFU `Req`.
- `ifu_stall`  out  1  to IFU `stall`.
- `ifu_npc`  out  32  to IFU `npc`.
- `fd_flush`  out  1  F/D register loads a bubble.
- `f_valid`  out  1  F instruction is real and advances.
- `f_bd`  out  1  F instruction is a delay slot (feeds CP0 BD).

## Operation
**FSM and pending state**
- Two-state FSM: RUN and PEND.
- Pending registers: `pend_tgt[31:0]`, `pend_bd`.

**Redirect priority (highest first)**
1. `exc_req`
2. `eret_d`
3. PEND redirect
4. `br_taken_d`
5. sequential (`pc_f + 4`, 32-bit wrap)

**Rules by source**
- `eret_d`, `br_d` and `br_taken_d` are ignored while `hz_stall=1`. The hazard unit only asserts them when the D operands are final.
- **`exc_req`:**
  - Outputs: `ifu_req=1`, `fd_flush=1`, `f_valid=0`.
  - Overrides `hz_stall` and `imem_ready`.
  - Next state RUN; pending registers cleared.
- **`eret_d`:**
  - Outputs: `ifu_npc=epc`, `ifu_stall=0`, `fd_flush=1`.
  - No delay slot; any outstanding fetch is abandoned.
- **Sequential:** `ifu_stall = hz_stall | ~imem_ready`.
- **`f_valid`:** `imem_ready & ~hz_stall & ~fd_flush`.
- **Instruction-memory miss:** `imem_ready=0` with `hz_stall=0` gives `fd_flush=1`, so a bubble enters D while D advances.

**Branch handling with DELAY_SLOT_EN**
- `br_taken_d` with `imem_ready=1`: `ifu_npc=br_target_d`, `ifu_stall=0`, `f_bd=1`.
- `br_taken_d` with `imem_ready=0`: latch `pend_tgt=br_target_d`, `pend_bd=1`, go to PEND.
- In PEND, while `imem_ready=0`: `ifu_stall=1`, `fd_flush=1`, `f_valid=0`.
- In PEND, on `imem_ready=1` and `hz_stall=0`: `ifu_npc=pend_tgt`, `f_bd=1`, `f_valid=1`, go to RUN.
- In PEND with `hz_stall=1`: stay in PEND.
- Not-taken `br_d` with `imem_ready=0`: latch `pend_bd` only and stay in RUN. `f_bd=1` when that fetch completes.
- In general, `f_bd = br_d | pend_bd`, under the `hz_stall` gating above.

**Priority and reset**
- `exc_req` or `eret_d` in PEND discards the pending redirect.
- `reset` has priority over everything: state RUN, pending registers cleared.

## Timing
**Latency**
- All steering outputs (`ifu_req`, `ifu_stall`, `ifu_npc`, `fd_flush`, `f_valid`, `f_bd`) are combinational from the current inputs and state.
- Redirect latency: target visible on `pc_f` one edge after the request cycle.
- PEND latency: target on `pc_f` one edge after the `imem_ready` cycle.

**Output values during and after reset**
- `ifu_req=0`
- `fd_flush=0`
- `f_bd=0`
- `ifu_npc=pc_f+4`
- `ifu_stall = hz_stall | ~imem_ready`

**Simultaneous events**
- `exc_req` together with `br_taken_d`: exception wins, branch dropped.
- `eret_d` together with a miss: redirect is immediate.

## Configuration
`DELAY_SLOT_EN`

**Defined:** MIPS branch delay slots; PEND state and `f_bd` behave as above.

**Undefined:**
- `br_taken_d` redirects immediately, like `eret` (`ifu_npc=br_target_d`, `ifu_stall=0`, `fd_flush=1`), regardless of `imem_ready`.
- PEND is unreachable and `f_bd` is tied to 0.

## Test plan
- Reset, then `imem_ready=1` for 3 cycles → `pc_f` 0x3000, 0x3004, 0x3008; `f_valid=1` each cycle; `ifu_req=0`.
- `exc_req=1` while `hz_stall=1` and `imem_ready=0` → `ifu_req=1`, `fd_flush=1`; next `pc_f=0x4180`.
- DS on: `br_taken_d=1`, target 0x3100, `pc_f=0x3008`, `imem_ready=1` → `f_bd=1`, `f_valid=1`; next `pc_f=0x3100`.
- DS on: same branch with `imem_ready=0` for 2 cycles, then 1 → state PEND; `pc_f` holds 0x3008 with `f_valid=0` ×2; then `f_bd=1`; next `pc_f=0x3100`.
- In PEND, assert `eret_d` with `epc=0x3040` → pending redirect dropped, `fd_flush=1`; next `pc_f=0x3040`, state RUN.
- DS off: `br_taken_d` with target 0x3200 → `fd_flush=1`, `f_bd=0`; next `pc_f=0x3200`.

Source files
------------

// File: rtl/fetch_sched_if.sv
// Fetch-scheduler bus: IFU/hazard/CP0/D-stage inputs and IFU steering outputs.
// slave = fetch_sched side, master = core/IFU side.
interface fetch_sched_if;
  logic [31:0] pc_f;
  logic        imem_ready;
  logic        hz_stall;
  logic        exc_req;
  logic        eret_d;
  logic [31:0] epc;
  logic        br_d;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic        ifu_req;
  logic        ifu_stall;
  logic [31:0] ifu_npc;
  logic        fd_flush;
  logic        f_valid;
  logic        f_bd;

  modport slave (
    input  pc_f, imem_ready, hz_stall, exc_req, eret_d, epc,
           br_d, br_taken_d, br_target_d,
    output ifu_req, ifu_stall, ifu_npc, fd_flush, f_valid, f_bd
  );

  modport master (
    output pc_f, imem_ready, hz_stall, exc_req, eret_d, epc,
           br_d, br_taken_d, br_target_d,
    input  ifu_req, ifu_stall, ifu_npc, fd_flush, f_valid, f_bd
  );
endinterface

// File: rtl/fetch_sched.sv
// Fetch-stage redirect/stall arbiter for the MIPS IFU.
// Optional feature: DELAY_SLOT_EN (branch delay slots, PEND state, f_bd).
module fetch_sched #(
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic         clk,
  input logic         reset,
  fetch_sched_if.slave bus
);
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  // IFU owns the reset PC; kept only as a documented parameter.
  localparam logic [31:0] unused_reset_pc = RESET_PC;

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, state_n;
  logic [31:0] pend_tgt, pend_tgt_n;
  logic        pend_bd, pend_bd_n;

  logic [31:0] seq_pc;
  logic        br_ok, brt_ok, eret_ok;
  logic        req, stall, flush, bd;
  logic [31:0] npc;

  assign seq_pc  = bus.pc_f + 32'd4;
  // D-stage requests are only trusted once the hazard unit releases D
  assign br_ok   = bus.br_d       & ~bus.hz_stall;
  assign brt_ok  = bus.br_taken_d & ~bus.hz_stall;
  assign eret_ok = bus.eret_d     & ~bus.hz_stall;

  always_ff @(posedge clk) begin
    state    <= state_n;
    pend_tgt <= pend_tgt_n;
    pend_bd  <= pend_bd_n;
  end

  always_comb begin
    state_n    = state;
    pend_tgt_n = pend_tgt;
    pend_bd_n  = pend_bd;
    req        = 1'b0;
    stall      = bus.hz_stall | ~bus.imem_ready;
    npc        = seq_pc;
    flush      = 1'b0;
    bd         = 1'b0;
    if (reset) begin
      state_n    = RUN;
      pend_tgt_n = '0;
      pend_bd_n  = 1'b0;
    end else if (bus.exc_req) begin
      req        = 1'b1;
      stall      = 1'b0;
      npc        = EXC_VEC;
      flush      = 1'b1;
      state_n    = RUN;
      pend_tgt_n = '0;
      pend_bd_n  = 1'b0;
    end else if (eret_ok) begin
      npc        = bus.epc;
      stall      = 1'b0;
      flush      = 1'b1;
      state_n    = RUN;
      pend_tgt_n = '0;
      pend_bd_n  = 1'b0;
    end else if (state == PEND) begin
      // delay slot still outstanding; the redirect waits for it
      bd = pend_bd;
      if (bus.hz_stall) begin
        stall = 1'b1;
      end else if (!bus.imem_ready) begin
        stall = 1'b1;
        flush = 1'b1;
      end else begin
        npc        = pend_tgt;
        stall      = 1'b0;
        state_n    = RUN;
        pend_tgt_n = '0;
        pend_bd_n  = 1'b0;
      end
    end else if (brt_ok) begin
      if (!DS) begin
        npc   = bus.br_target_d;
        stall = 1'b0;
        flush = 1'b1;
      end else if (bus.imem_ready) begin
        npc       = bus.br_target_d;
        stall     = 1'b0;
        bd        = 1'b1;
        pend_bd_n = 1'b0;
      end else begin
        stall      = 1'b1;
        flush      = 1'b1;
        bd         = 1'b1;
        pend_tgt_n = bus.br_target_d;
        pend_bd_n  = 1'b1;
        state_n    = PEND;
      end
    end else begin
      flush = ~bus.imem_ready & ~bus.hz_stall;
      if (DS) begin
        // not-taken branch over a miss: remember the slot until it lands
        bd = br_ok | pend_bd;
        if (bus.imem_ready && !bus.hz_stall) pend_bd_n = 1'b0;
        else if (br_ok)                      pend_bd_n = 1'b1;
      end
    end
  end

  assign bus.ifu_req   = req;
  assign bus.ifu_stall = stall;
  assign bus.ifu_npc   = npc;
  assign bus.fd_flush  = flush;
  assign bus.f_valid   = bus.imem_ready & ~bus.hz_stall & ~flush;
  assign bus.f_bd      = DS & bd;
endmodule
